// File: rtl/dcarb_pkg.sv
// Shared types and defaults for the data-cache port arbiter.
package dcarb_pkg;

   localparam int DEF_ADDR_W     = 12;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_RD_LAT     = 1;
   localparam int DEF_STARVE_MAX = 4;
   localparam int STARVE_W       = 4;
   localparam int PERF_W         = 16;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_DBG  = 2'd2
   } owner_e;

   typedef struct packed {
      logic                      we;
      logic [DEF_ADDR_W-1:0]     addr;
      logic [DEF_DATA_W/8-1:0]   wmask;
      logic [DEF_DATA_W-1:0]     wdata;
   } mem_req_t;

   // Saturating increment used by the optional performance counters.
   function automatic logic [PERF_W-1:0] satInc(input logic [PERF_W-1:0] value);
      return (value == {PERF_W{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/dcarb_rd_pipe.sv
// Read-return tracker: RD_LAT-deep {valid, owner} shift register that
// steers SRAM read data to whichever requester issued the read.
module dcarb_rd_pipe
   import dcarb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push_valid,
   input  owner_e            i_push_owner,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_core_rvalid,
   output logic [DATA_W-1:0] o_core_rdata,
   output logic              o_dbg_rvalid,
   output logic [DATA_W-1:0] o_dbg_rdata
);

   logic              r_valid [RD_LAT];
   owner_e            r_owner [RD_LAT];
   logic [DATA_W-1:0] r_core_rdata;
   logic [DATA_W-1:0] r_dbg_rdata;
   logic              w_tail_valid;
   logic              w_core_hit;
   logic              w_dbg_hit;

   // The tail is gated by rst so a read that was in flight never surfaces.
   assign w_tail_valid = r_valid[RD_LAT-1] && !rst;
   assign w_core_hit   = w_tail_valid && (r_owner[RD_LAT-1] == OWN_CORE);
   assign w_dbg_hit    = w_tail_valid && (r_owner[RD_LAT-1] == OWN_DBG);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_valid[i] <= 1'b0;
            r_owner[i] <= OWN_NONE;
         end
         r_core_rdata <= '0;
         r_dbg_rdata  <= '0;
      end else begin
         r_valid[0] <= i_push_valid;
         r_owner[0] <= i_push_owner;
         for (int i = 1; i < RD_LAT; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_owner[i] <= r_owner[i-1];
         end
         if (w_core_hit) begin
            r_core_rdata <= i_mem_rdata;
         end
         if (w_dbg_hit) begin
            r_dbg_rdata <= i_mem_rdata;
         end
      end
   end

   // Returned data passes straight through on its valid cycle and is held afterwards.
   assign o_core_rvalid = w_core_hit;
   assign o_dbg_rvalid  = w_dbg_hit;
   assign o_core_rdata  = w_core_hit ? i_mem_rdata : r_core_rdata;
   assign o_dbg_rdata   = w_dbg_hit  ? i_mem_rdata : r_dbg_rdata;

endmodule

// File: rtl/dcache_port_arbiter.sv
// Two-requester arbiter for the single data-cache SRAM port (core priority,
// starvation-protected debug port). Optional counters: define DCARB_PERF_EN.
module dcache_port_arbiter
   import dcarb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int RD_LAT     = DEF_RD_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                core_req,
   input  logic                core_we,
   input  logic [ADDR_W-1:0]   core_addr,
   input  logic [DATA_W/8-1:0] core_wmask,
   input  logic [DATA_W-1:0]   core_wdata,
   output logic                core_gnt,
   output logic                core_rvalid,
   output logic [DATA_W-1:0]   core_rdata,
   input  logic                dbg_req,
   input  logic                dbg_we,
   input  logic [ADDR_W-1:0]   dbg_addr,
   input  logic [DATA_W/8-1:0] dbg_wmask,
   input  logic [DATA_W-1:0]   dbg_wdata,
   output logic                dbg_gnt,
   output logic                dbg_rvalid,
   output logic [DATA_W-1:0]   dbg_rdata,
   output logic                mem_cen,
   output logic                mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_wmask,
   output logic [DATA_W-1:0]   mem_wdata,
`ifdef DCARB_PERF_EN
   output logic [PERF_W-1:0]   perf_core_gnt,
   output logic [PERF_W-1:0]   perf_dbg_gnt,
   output logic [PERF_W-1:0]   perf_conflict,
`endif
   input  logic [DATA_W-1:0]   mem_rdata
);

   logic                w_core_gnt;
   logic                w_dbg_gnt;
   logic                w_conflict;
   logic                w_starved;
   logic                w_rd_push;
   owner_e              w_owner;
   logic [STARVE_W-1:0] r_starve_cnt;

   assign w_conflict = core_req && dbg_req;
   assign w_starved  = (r_starve_cnt == STARVE_W'(STARVE_MAX));

   // Core wins unless debug has been denied STARVE_MAX cycles in a row.
   always_comb begin
      w_core_gnt = 1'b0;
      w_dbg_gnt  = 1'b0;
      if (!rst) begin
         if (core_req && !(dbg_req && w_starved)) begin
            w_core_gnt = 1'b1;
         end else if (dbg_req) begin
            w_dbg_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      mem_cen   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wmask = '0;
      mem_wdata = '0;
      w_owner   = OWN_NONE;
      if (w_core_gnt) begin
         mem_cen   = 1'b1;
         mem_wen   = core_we;
         mem_addr  = core_addr;
         mem_wmask = core_wmask;
         mem_wdata = core_wdata;
         w_owner   = OWN_CORE;
      end else if (w_dbg_gnt) begin
         mem_cen   = 1'b1;
         mem_wen   = dbg_we;
         mem_addr  = dbg_addr;
         mem_wmask = dbg_wmask;
         mem_wdata = dbg_wdata;
         w_owner   = OWN_DBG;
      end
   end

   // A pending, ungranted debug request implies the core took the slot.
   always_ff @(posedge clk) begin
      if (rst || !dbg_req || w_dbg_gnt) begin
         r_starve_cnt <= '0;
      end else if (!w_starved) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   assign core_gnt  = w_core_gnt;
   assign dbg_gnt   = w_dbg_gnt;
   assign w_rd_push = mem_cen && !mem_wen;

   dcarb_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk           (clk),
      .rst           (rst),
      .i_push_valid  (w_rd_push),
      .i_push_owner  (w_owner),
      .i_mem_rdata   (mem_rdata),
      .o_core_rvalid (core_rvalid),
      .o_core_rdata  (core_rdata),
      .o_dbg_rvalid  (dbg_rvalid),
      .o_dbg_rdata   (dbg_rdata)
   );

`ifdef DCARB_PERF_EN
   owner_e            r_last_owner;
   logic              r_last_conflict;
   logic [PERF_W-1:0] r_perf_core;
   logic [PERF_W-1:0] r_perf_dbg;
   logic [PERF_W-1:0] r_perf_conflict;

   // Counters work from the registered per-cycle owner, so they trail grants by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_owner    <= OWN_NONE;
         r_last_conflict <= 1'b0;
         r_perf_core     <= '0;
         r_perf_dbg      <= '0;
         r_perf_conflict <= '0;
      end else begin
         r_last_owner    <= w_owner;
         r_last_conflict <= w_conflict;
         if (r_last_owner == OWN_CORE) begin
            r_perf_core <= satInc(r_perf_core);
         end
         if (r_last_owner == OWN_DBG) begin
            r_perf_dbg <= satInc(r_perf_dbg);
         end
         if (r_last_conflict) begin
            r_perf_conflict <= satInc(r_perf_conflict);
         end
      end
   end

   assign perf_core_gnt = r_perf_core;
   assign perf_dbg_gnt  = r_perf_dbg;
   assign perf_conflict = r_perf_conflict;
`else
   logic w_unused_conflict;
   assign w_unused_conflict = w_conflict;
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench: one arbiter at RD_LAT=1 and one at RD_LAT=3, shared stimulus,
// each backed by a simple byte-masked SRAM model.
module tb_dcache_port_arbiter;

   logic        clk;
   logic        rst;
   logic        core_req, core_we, dbg_req, dbg_we;
   logic [11:0] core_addr, dbg_addr;
   logic [3:0]  core_wmask, dbg_wmask;
   logic [31:0] core_wdata, dbg_wdata;

   logic        core_gnt1, core_rvalid1, dbg_gnt1, dbg_rvalid1, mem_cen1, mem_wen1;
   logic [31:0] core_rdata1, dbg_rdata1, mem_wdata1, mem_rdata1;
   logic [11:0] mem_addr1;
   logic [3:0]  mem_wmask1;

   logic        core_gnt3, core_rvalid3, dbg_gnt3, dbg_rvalid3, mem_cen3, mem_wen3;
   logic [31:0] core_rdata3, dbg_rdata3, mem_wdata3, mem_rdata3;
   logic [11:0] mem_addr3;
   logic [3:0]  mem_wmask3;

`ifdef DCARB_PERF_EN
   logic [15:0] perfCore1, perfDbg1, perfConf1, perfCore3, perfDbg3, perfConf3;
`endif

   int checks;
   int errors;

   dcache_port_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wmask(core_wmask), .core_wdata(core_wdata),
      .core_gnt(core_gnt1), .core_rvalid(core_rvalid1), .core_rdata(core_rdata1),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wmask(dbg_wmask), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rdata(dbg_rdata1),
      .mem_cen(mem_cen1), .mem_wen(mem_wen1), .mem_addr(mem_addr1),
      .mem_wmask(mem_wmask1), .mem_wdata(mem_wdata1),
`ifdef DCARB_PERF_EN
      .perf_core_gnt(perfCore1), .perf_dbg_gnt(perfDbg1), .perf_conflict(perfConf1),
`endif
      .mem_rdata(mem_rdata1)
   );

   dcache_port_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wmask(core_wmask), .core_wdata(core_wdata),
      .core_gnt(core_gnt3), .core_rvalid(core_rvalid3), .core_rdata(core_rdata3),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wmask(dbg_wmask), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt3), .dbg_rvalid(dbg_rvalid3), .dbg_rdata(dbg_rdata3),
      .mem_cen(mem_cen3), .mem_wen(mem_wen3), .mem_addr(mem_addr3),
      .mem_wmask(mem_wmask3), .mem_wdata(mem_wdata3),
`ifdef DCARB_PERF_EN
      .perf_core_gnt(perfCore3), .perf_dbg_gnt(perfDbg3), .perf_conflict(perfConf3),
`endif
      .mem_rdata(mem_rdata3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  mask);
      logic [31:0] result;
      result = oldWord;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) result[b*8 +: 8] = newWord[b*8 +: 8];
      end
      return result;
   endfunction

   // SRAM models, preloaded whenever rst is high.
   logic [31:0] mem1 [0:4095];
   logic [31:0] mem3 [0:4095];
   logic [31:0] rd1, rd3a, rd3b, rd3c;

   always @(posedge clk) begin
      if (rst) begin
         mem1[12'h010] <= 32'hDEADBEEF;
         mem1[12'h020] <= 32'hAAAAAAAA;
         for (int i = 0; i < 4; i++) mem1[12'h100 + i] <= 32'hC0DE0000 + i;
      end else if (mem_cen1 && mem_wen1) begin
         mem1[mem_addr1] <= mergeBytes(mem1[mem_addr1], mem_wdata1, mem_wmask1);
      end
      rd1 <= (mem_cen1 && !mem_wen1) ? mem1[mem_addr1] : 32'h0;
   end
   assign mem_rdata1 = rd1;

   always @(posedge clk) begin
      if (rst) begin
         mem3[12'h010] <= 32'hDEADBEEF;
         mem3[12'h020] <= 32'hAAAAAAAA;
         for (int i = 0; i < 4; i++) mem3[12'h100 + i] <= 32'hC0DE0000 + i;
      end else if (mem_cen3 && mem_wen3) begin
         mem3[mem_addr3] <= mergeBytes(mem3[mem_addr3], mem_wdata3, mem_wmask3);
      end
      rd3a <= (mem_cen3 && !mem_wen3) ? mem3[mem_addr3] : 32'h0;
      rd3b <= rd3a;
      rd3c <= rd3b;
   end
   assign mem_rdata3 = rd3c;

   task automatic applyStimulus(input logic iRst,
                                input logic iCoreReq, input logic iCoreWe,
                                input logic [11:0] iCoreAddr, input logic [3:0] iCoreMask,
                                input logic [31:0] iCoreData,
                                input logic iDbgReq, input logic iDbgWe,
                                input logic [11:0] iDbgAddr, input logic [3:0] iDbgMask,
                                input logic [31:0] iDbgData);
      @(negedge clk);
      rst        = iRst;
      core_req   = iCoreReq;
      core_we    = iCoreWe;
      core_addr  = iCoreAddr;
      core_wmask = iCoreMask;
      core_wdata = iCoreData;
      dbg_req    = iDbgReq;
      dbg_we     = iDbgWe;
      dbg_addr   = iDbgAddr;
      dbg_wmask  = iDbgMask;
      dbg_wdata  = iDbgData;
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
   endtask

   task automatic coreRead(input logic [11:0] addr);
      applyStimulus(1'b0, 1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
   endtask

   task automatic dbgRead(input logic [11:0] addr);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 1'b0, addr, 4'h0, 32'h0);
   endtask

   task automatic bothRead(input logic iRst, input logic [11:0] cAddr, input logic [11:0] dAddr);
      applyStimulus(iRst, 1'b1, 1'b0, cAddr, 4'h0, 32'h0, 1'b1, 1'b0, dAddr, 4'h0, 32'h0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
         $error("[TB] check %s failed", tag);
      end
   endtask

   initial begin
      logic expD;
      logic expCore, expDbg;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wmask = '0; core_wdata = '0;
      dbg_req = 1'b0;  dbg_we = 1'b0;  dbg_addr = '0;  dbg_wmask = '0;  dbg_wdata = '0;

      // Reset with both requesting: nothing may be granted.
      bothRead(1'b1, 12'h010, 12'h020);
      checkOutput("rst_core_gnt", 32'(core_gnt1), 32'd0);
      checkOutput("rst_dbg_gnt", 32'(dbg_gnt1), 32'd0);
      checkOutput("rst_mem_cen", 32'(mem_cen1), 32'd0);
      checkOutput("rst_mem_cen3", 32'(mem_cen3), 32'd0);
      checkOutput("rst_core_rvalid", 32'(core_rvalid1), 32'd0);
      checkOutput("rst_core_rdata", core_rdata1, 32'h0);
      checkOutput("rst_dbg_rdata", dbg_rdata1, 32'h0);
      idleCycle();

      // Continuous conflict: C,C,C,C,D repeating.
      for (int k = 0; k < 10; k++) begin
         bothRead(1'b0, 12'h010, 12'h020);
         expD = ((k % 5) == 4);
         checkOutput($sformatf("starve_core_gnt%0d", k), 32'(core_gnt1), 32'(!expD));
         checkOutput($sformatf("starve_dbg_gnt%0d", k), 32'(dbg_gnt1), 32'(expD));
         checkOutput($sformatf("starve_onehot%0d", k), 32'(core_gnt1 & dbg_gnt1), 32'd0);
      end
      idleCycle();
      checkOutput("starve_dbg_rvalid", 32'(dbg_rvalid1), 32'd1);
      checkOutput("starve_dbg_rdata", dbg_rdata1, 32'hAAAAAAAA);
      idleCycle();
`ifdef DCARB_PERF_EN
      checkOutput("perf_core_gnt", 32'(perfCore1), 32'd8);
      checkOutput("perf_dbg_gnt", 32'(perfDbg1), 32'd2);
      checkOutput("perf_conflict", 32'(perfConf1), 32'd10);
`endif

      // Core-only read, RD_LAT=1.
      coreRead(12'h010);
      checkOutput("rd_core_gnt", 32'(core_gnt1), 32'd1);
      checkOutput("rd_mem_cen", 32'(mem_cen1), 32'd1);
      checkOutput("rd_mem_wen", 32'(mem_wen1), 32'd0);
      checkOutput("rd_mem_addr", 32'(mem_addr1), 32'h010);
      idleCycle();
      checkOutput("rd_core_rvalid", 32'(core_rvalid1), 32'd1);
      checkOutput("rd_core_rdata", core_rdata1, 32'hDEADBEEF);
      checkOutput("rd_dbg_rvalid", 32'(dbg_rvalid1), 32'd0);
      idleCycle();
      checkOutput("rd_core_rvalid_once", 32'(core_rvalid1), 32'd0);
      checkOutput("rd_core_rdata_hold", core_rdata1, 32'hDEADBEEF);
      checkOutput("idle_mem_cen", 32'(mem_cen1), 32'd0);
      checkOutput("idle_mem_addr", 32'(mem_addr1), 32'h0);

      // Masked debug write followed by core read of the same word.
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 1'b1, 12'h020, 4'b0011, 32'h12345678);
      checkOutput("wr_dbg_gnt", 32'(dbg_gnt1), 32'd1);
      checkOutput("wr_mem_wen", 32'(mem_wen1), 32'd1);
      checkOutput("wr_mem_addr", 32'(mem_addr1), 32'h020);
      checkOutput("wr_mem_wmask", 32'(mem_wmask1), 32'h3);
      checkOutput("wr_mem_wdata", mem_wdata1, 32'h12345678);
      coreRead(12'h020);
      checkOutput("raw_core_gnt", 32'(core_gnt1), 32'd1);
      idleCycle();
      checkOutput("raw_core_rvalid", 32'(core_rvalid1), 32'd1);
      checkOutput("raw_core_rdata", core_rdata1, 32'hAAAA5678);
      checkOutput("raw_dbg_rvalid", 32'(dbg_rvalid1), 32'd0);
      checkOutput("raw_dbg_rdata_hold", dbg_rdata1, 32'hAAAAAAAA);
      repeat (4) idleCycle();

      // Alternating reads on the RD_LAT=3 instance.
      for (int c = 0; c < 8; c++) begin
         if (c < 4) begin
            if ((c % 2) == 0) coreRead(12'h100 + 12'(c));
            else              dbgRead(12'h100 + 12'(c));
            if ((c % 2) == 0) checkOutput($sformatf("alt_core_gnt%0d", c), 32'(core_gnt3), 32'd1);
            else              checkOutput($sformatf("alt_dbg_gnt%0d", c), 32'(dbg_gnt3), 32'd1);
         end else begin
            idleCycle();
         end
         expCore = (c >= 3) && (c <= 6) && (((c - 3) % 2) == 0);
         expDbg  = (c >= 3) && (c <= 6) && (((c - 3) % 2) == 1);
         checkOutput($sformatf("alt_core_rvalid%0d", c), 32'(core_rvalid3), 32'(expCore));
         checkOutput($sformatf("alt_dbg_rvalid%0d", c), 32'(dbg_rvalid3), 32'(expDbg));
         if (expCore) checkOutput($sformatf("alt_core_rdata%0d", c), core_rdata3, 32'hC0DE0000 + 32'(c - 3));
         if (expDbg)  checkOutput($sformatf("alt_dbg_rdata%0d", c), dbg_rdata3, 32'hC0DE0000 + 32'(c - 3));
      end

      // Reset with reads in flight and a partly built starvation count.
      bothRead(1'b0, 12'h100, 12'h101);
      bothRead(1'b0, 12'h100, 12'h101);
      bothRead(1'b1, 12'h100, 12'h101);
      checkOutput("rst2_core_gnt", 32'(core_gnt1), 32'd0);
      checkOutput("rst2_dbg_gnt", 32'(dbg_gnt1), 32'd0);
      checkOutput("rst2_mem_cen", 32'(mem_cen1), 32'd0);
      checkOutput("rst2_mem_cen3", 32'(mem_cen3), 32'd0);
      checkOutput("rst2_core_rvalid", 32'(core_rvalid1), 32'd0);
      for (int k = 0; k < 5; k++) begin
         bothRead(1'b0, 12'h100, 12'h101);
         expD = (k == 4);
         checkOutput($sformatf("rst2_core_gnt%0d", k), 32'(core_gnt1), 32'(!expD));
         checkOutput($sformatf("rst2_dbg_gnt%0d", k), 32'(dbg_gnt1), 32'(expD));
         if (k < 3) begin
            checkOutput($sformatf("rst2_core_rvalid3_%0d", k), 32'(core_rvalid3), 32'd0);
            checkOutput($sformatf("rst2_dbg_rvalid3_%0d", k), 32'(dbg_rvalid3), 32'd0);
         end
         if (k == 0) begin
            checkOutput("rst2_core_rdata1", core_rdata1, 32'h0);
            checkOutput("rst2_core_rdata3", core_rdata3, 32'h0);
         end
      end
      repeat (4) idleCycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
